// File: rtl/sram_rw_init_ext.sv
// Single-port SRAM with per-lane write mask, configurable read latency and a
// self-clearing sequence that fills every word with INIT_VAL after reset or on request.
module sram_rw_init_ext #(
    parameter int unsigned         DATA_W   = 86,
    parameter int unsigned         DEPTH    = 256,
    parameter int unsigned         ADDR_W   = 8,
    parameter int unsigned         MASK_W   = 2,
    parameter int unsigned         RD_LAT   = 1,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
    input  logic              RW0_clk,
    input  logic              RW0_reset,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_ready,
    input  logic              clear_req
);

    localparam int unsigned      LANE_W = DATA_W / MASK_W;
    localparam int unsigned      CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               in_range;
    logic [CNT_W-1:0]   mem_idx;
    logic               rd_acc;
    logic [DATA_W-1:0]  rd_word;

    logic [CNT_W-1:0]   wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [MASK_W-1:0]  wr_lane;

    logic               pipe_valid;
    logic [DATA_W-1:0]  pipe_data;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                if (cnt_q == LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                if (clear_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RW0_ready = (state_q == StRun);

    // ---------------------------------------------------------------- access decode
    // Widen before comparing so DEPTH == 2**ADDR_W does not truncate to zero.
    assign in_range = (32'(RW0_addr) < DEPTH);
    assign mem_idx  = RW0_addr[CNT_W-1:0];
    assign rd_acc   = RW0_ready && RW0_en && !RW0_wmode;
    assign rd_word  = in_range ? mem[mem_idx] : '0;

    always_comb begin
        wr_addr = mem_idx;
        wr_data = RW0_wdata;
        wr_lane = '0;
        if (state_q == StClear) begin
            wr_addr = cnt_q;
            wr_data = INIT_VAL;
            wr_lane = '1;
        end else if (RW0_en && RW0_wmode && in_range) begin
            wr_lane = RW0_wmask;
        end
    end

    // Storage has no reset; contents are defined only by the clear sequence.
    always_ff @(posedge RW0_clk) begin
        for (int i = 0; i < MASK_W; i++) begin
            if (wr_lane[i]) begin
                mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    // ---------------------------------------------------------------- read pipeline
    if (RD_LAT == 2) begin : g_lat2
        logic              s1_valid_q;
        logic [DATA_W-1:0] s1_data_q;

        always_ff @(posedge RW0_clk or posedge RW0_reset) begin
            if (RW0_reset) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_acc;
                if (rd_acc) begin
                    s1_data_q <= rd_word;
                end
            end
        end

        assign pipe_valid = s1_valid_q;
        assign pipe_data  = s1_data_q;
    end else begin : g_lat1
        assign pipe_valid = rd_acc;
        assign pipe_data  = rd_word;
    end

    // Output register holds the last completed read until the next one lands.
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pipe_valid;
            if (pipe_valid) begin
                rdata_q <= pipe_data;
            end
        end
    end

    assign RW0_rvalid = rvalid_q;
    assign RW0_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_rw_init_ext.sv
// Scoreboard bench: two instances (defaults / DEPTH=200, RD_LAT=2, non-zero INIT_VAL)
// share one randomized stimulus stream and are checked against an abstract memory model.
module tb_sram_rw_init_ext;

    localparam int DW = 86;
    localparam int NI = 2;
    localparam int LW = 43;
    localparam logic [DW-1:0] INIT_B = 86'h3_4567_89AB_CDEF_0123_4567;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    addr = '0;
    logic          en = 1'b0;
    logic          wmode = 1'b0;
    logic [1:0]    wmask = '0;
    logic [DW-1:0] wdata = '0;
    logic          clear_req = 1'b0;

    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, ready_a, ready_b;

    always #5 clk = ~clk;

    sram_rw_init_ext dut_a (
        .RW0_clk   (clk),
        .RW0_reset (rst),
        .RW0_addr  (addr),
        .RW0_en    (en),
        .RW0_wmode (wmode),
        .RW0_wmask (wmask),
        .RW0_wdata (wdata),
        .RW0_rdata (rdata_a),
        .RW0_rvalid(rvalid_a),
        .RW0_ready (ready_a),
        .clear_req (clear_req)
    );

    sram_rw_init_ext #(
        .DATA_W  (86),
        .DEPTH   (200),
        .ADDR_W  (8),
        .MASK_W  (2),
        .RD_LAT  (2),
        .INIT_VAL(INIT_B)
    ) dut_b (
        .RW0_clk   (clk),
        .RW0_reset (rst),
        .RW0_addr  (addr),
        .RW0_en    (en),
        .RW0_wmode (wmode),
        .RW0_wmask (wmask),
        .RW0_wdata (wdata),
        .RW0_rdata (rdata_b),
        .RW0_rvalid(rvalid_b),
        .RW0_ready (ready_b),
        .clear_req (clear_req)
    );

    function automatic int dep(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [DW-1:0] init_of(input int k);
        return (k == 0) ? '0 : INIT_B;
    endfunction

    // ---------------------------------------------------------------- reference model
    logic [DW-1:0] mem_m [NI][256];
    int            clr_left [NI];
    logic [DW-1:0] sb [NI][$];
    int            due_q [NI][$];
    int            cyc = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                clr_left[k] = dep(k);
                sb[k].delete();
                due_q[k].delete();
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < NI; k++) begin
                if (clr_left[k] > 0) begin
                    clr_left[k] = clr_left[k] - 1;
                    if (clr_left[k] == 0) begin
                        for (int a = 0; a < 256; a++) mem_m[k][a] = init_of(k);
                    end
                end else begin
                    if (en && wmode && int'(addr) < dep(k)) begin
                        for (int l = 0; l < 2; l++) begin
                            if (wmask[l]) mem_m[k][addr][l*LW +: LW] = wdata[l*LW +: LW];
                        end
                    end
                    if (en && !wmode) begin
                        sb[k].push_back((int'(addr) < dep(k)) ? mem_m[k][addr] : '0);
                        due_q[k].push_back(cyc + lat(k) - 1);
                    end
                    if (clear_req) clr_left[k] = dep(k);
                end
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_rd [NI];
    logic [DW-1:0] rd_w [NI];
    logic          rv_w [NI];
    logic          rdy_w [NI];

    assign rd_w[0]  = rdata_a;
    assign rd_w[1]  = rdata_b;
    assign rv_w[0]  = rvalid_a;
    assign rv_w[1]  = rvalid_b;
    assign rdy_w[0] = ready_a;
    assign rdy_w[1] = ready_b;

    task automatic chk(input string nm, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) exp_rd[k] = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk("ready", k, DW'(rdy_w[k]), DW'(clr_left[k] == 0 && !rst));
                if (rv_w[k] === 1'b1) begin
                    if (sb[k].size() == 0) begin
                        chk("spurious_rvalid", k, DW'(1), DW'(0));
                    end else begin
                        exp_rd[k] = sb[k].pop_front();
                        chk("rvalid_latency", k, DW'(cyc), DW'(due_q[k].pop_front()));
                    end
                end else if (due_q[k].size() > 0 && due_q[k][0] <= cyc) begin
                    chk("missing_rvalid", k, DW'(rv_w[k]), DW'(1));
                    void'(due_q[k].pop_front());
                    void'(sb[k].pop_front());
                end
                if (rst) exp_rd[k] = '0;
                chk("rdata", k, rd_w[k], exp_rd[k]);
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic step(input bit e, input bit w, input logic [7:0] a, input logic [1:0] m,
                        input logic [DW-1:0] d, input bit c);
        @(posedge clk);
        #2;
        en = e; wmode = w; addr = a; wmask = m; wdata = d; clear_req = c;
    endtask

    task automatic rnd_step(input int creq_den);
        logic [7:0]    a;
        logic [DW-1:0] d;
        bit            c;
        a = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255));
        d = {22'($urandom), $urandom, $urandom};
        c = (creq_den > 0) && ($urandom_range(creq_den - 1) == 0);
        step($urandom_range(9) < 7, $urandom_range(1) == 1, a, 2'($urandom_range(3)), d, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'd0, 2'd0, '0, 0);
    endtask

    task automatic set_rst(input bit v);
        @(posedge clk);
        #2;
        rst = v; en = 1'b0; clear_req = 1'b0;
    endtask

    initial begin
        idle(3);
        set_rst(0);
        // Clear after reset: accesses and clear_req must be ignored throughout.
        for (int i = 0; i < 198; i++) begin
            if (i == 10)      step(1, 1, 8'd7, 2'b11, {DW{1'b1}}, 0);
            else if (i == 50) step(1, 0, 8'd7, 2'b00, '0, 1);
            else              rnd_step(0);
        end
        idle(60);
        // Directed patterns.
        step(1, 0, 8'd0,   2'b00, '0, 0);
        step(1, 0, 8'd128, 2'b00, '0, 0);
        step(1, 0, 8'd255, 2'b00, '0, 0);
        step(1, 0, 8'd7,   2'b00, '0, 0);
        step(1, 1, 8'd5,   2'b01, {DW{1'b1}}, 0);
        step(1, 0, 8'd5,   2'b00, '0, 0);
        step(1, 1, 8'd1,   2'b11, 86'h11, 0);
        step(1, 1, 8'd2,   2'b11, 86'h22, 0);
        step(1, 1, 8'd3,   2'b11, 86'h33, 0);
        step(1, 0, 8'd1,   2'b00, '0, 0);
        step(1, 0, 8'd2,   2'b00, '0, 0);
        step(1, 0, 8'd3,   2'b00, '0, 0);
        step(1, 1, 8'd210, 2'b11, {DW{1'b1}}, 0);
        step(1, 0, 8'd210, 2'b00, '0, 0);
        step(1, 0, 8'd9,   2'b00, '0, 0);
        step(1, 1, 8'd4,   2'b00, {DW{1'b1}}, 0);
        step(1, 0, 8'd4,   2'b00, '0, 0);
        idle(3);
        // Random traffic with occasional clear requests.
        for (int i = 0; i < 3000; i++) rnd_step(500);
        idle(260);
        // Read in flight when reset hits.
        step(1, 0, 8'd3, 2'b00, '0, 0);
        set_rst(1);
        idle(2);
        set_rst(0);
        for (int i = 0; i < 300; i++) rnd_step(0);
        // Reset at clear cycle 100.
        step(0, 0, 8'd0, 2'b00, '0, 1);
        for (int i = 0; i < 99; i++) rnd_step(0);
        set_rst(1);
        idle(1);
        set_rst(0);
        for (int i = 0; i < 800; i++) rnd_step(0);
        idle(4);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
